// File: rtl/ula_sequencial_if.sv
// Launch/complete bus between the control unit and the sequential ALU.
// Master drives the request fields; slave returns status and registered results.
interface ula_sequencial_if #(
    parameter int LARGURA = 16
);
    logic                   inicio;
    logic [4:0]             opcode;
    logic [LARGURA-1:0]     operando1;
    logic [LARGURA-1:0]     operando2;
    logic                   ocupado;
    logic                   pronto;
    logic [2*LARGURA-1:0]   resultado;
    logic                   data_uc;
    logic                   erro_div0;

    modport master (
        output inicio, opcode, operando1, operando2,
        input  ocupado, pronto, resultado, data_uc, erro_div0
    );

    modport slave (
        input  inicio, opcode, operando1, operando2,
        output ocupado, pronto, resultado, data_uc, erro_div0
    );
endinterface

// File: rtl/ula_sequencial.sv
// Multi-cycle ALU: single-cycle ops pronto 1 cycle after acceptance, Mul/Div LARGURA+1 cycles.
// New requests are accepted only while idle; inicio during ocupado is dropped, all outputs registered.
module ula_sequencial #(
    parameter int LARGURA = 16
) (
    input  logic            clock,
    input  logic            reset,
    ula_sequencial_if.slave bus
);
    localparam int L  = LARGURA;
    localparam int CW = $clog2(LARGURA) + 1;

    localparam logic [4:0] OP_PUSH = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_MUL  = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_NAND = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_XOR  = 5'b01011;
    localparam logic [4:0] OP_CMP  = 5'b01100;
    localparam logic [4:0] OP_NOT  = 5'b01101;
    localparam logic [4:0] OP_IFEQ = 5'b01111;
    localparam logic [4:0] OP_IFGT = 5'b10000;
    localparam logic [4:0] OP_IFLT = 5'b10001;
    localparam logic [4:0] OP_IFGE = 5'b10010;
    localparam logic [4:0] OP_IFLE = 5'b10011;

    typedef enum logic [1:0] {OCIOSO, MUL, DIV, FIM} estado_t;

    estado_t          estado_q, estado_d;
    logic [L-1:0]     a_q, a_d;
    logic [L-1:0]     b_q, b_d;
    logic [2*L-1:0]   trab_q, trab_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*L-1:0]   resultado_q, resultado_d;
    logic             data_uc_q, data_uc_d;
    logic             erro_q, erro_d;
    logic             pronto_q, pronto_d;
    logic             ocupado_q, ocupado_d;

    logic [2*L-1:0]   imed_res;
    logic             imed_uc;
    logic             op1_neg, op1_zero;
    logic [L:0]       mul_soma;
    logic [2*L-1:0]   mul_prox;
    logic [L:0]       div_desl;
    logic             div_cabe;
    logic [L-1:0]     div_resto;
    logic [2*L-1:0]   div_prox;
    logic             ultima;

    assign op1_neg  = bus.operando1[L-1];
    assign op1_zero = (bus.operando1 == '0);

    // Shift-add: trab = {partial product, remaining multiplier bits}
    assign mul_soma = {1'b0, trab_q[2*L-1:L]} + {1'b0, a_q};
    assign mul_prox = trab_q[0] ? {mul_soma, trab_q[L-1:1]}
                                : {1'b0, trab_q[2*L-1:L], trab_q[L-1:1]};

    // Restoring division: trab = {remainder, dividend bits shifting out / quotient bits shifting in}
    assign div_desl  = {trab_q[2*L-1:L], trab_q[L-1]};
    assign div_cabe  = (div_desl >= {1'b0, b_q});
    assign div_resto = div_cabe ? L'(div_desl - {1'b0, b_q}) : div_desl[L-1:0];
    assign div_prox  = {div_resto, trab_q[L-2:0], div_cabe};

    assign ultima = (cnt_q == CW'(L - 1));

    always_comb begin
        imed_res = '0;
        imed_uc  = 1'b0;
        case (bus.opcode)
            OP_PUSH: imed_res = {{L{1'b0}}, bus.operando1};
            OP_ADD:  imed_res = {{L{1'b0}}, bus.operando1} + {{L{1'b0}}, bus.operando2};
            OP_SUB:  imed_res = {{L{1'b0}}, bus.operando1} - {{L{1'b0}}, bus.operando2};
            OP_AND:  imed_res = {{L{1'b0}}, bus.operando1 & bus.operando2};
            OP_NAND: imed_res = {{L{1'b0}}, ~(bus.operando1 & bus.operando2)};
            OP_OR:   imed_res = {{L{1'b0}}, bus.operando1 | bus.operando2};
            OP_XOR:  imed_res = {{L{1'b0}}, bus.operando1 ^ bus.operando2};
            OP_NOT:  imed_res = {{L{1'b0}}, ~bus.operando1};
            OP_CMP: begin
                if (bus.operando1 == bus.operando2)     imed_res = '0;
                else if (bus.operando1 > bus.operando2) imed_res = {{(2*L-1){1'b0}}, 1'b1};
                else                                    imed_res = '1;
            end
            OP_IFEQ: imed_uc = op1_zero;
            OP_IFGT: imed_uc = !op1_neg && !op1_zero;
            OP_IFLT: imed_uc = op1_neg;
            OP_IFGE: imed_uc = !op1_neg;
            OP_IFLE: imed_uc = op1_neg || op1_zero;
            default: ;
        endcase
    end

    always_comb begin
        estado_d    = estado_q;
        a_d         = a_q;
        b_d         = b_q;
        trab_d      = trab_q;
        cnt_d       = cnt_q;
        resultado_d = resultado_q;
        data_uc_d   = data_uc_q;
        erro_d      = erro_q;
        case (estado_q)
            OCIOSO: if (bus.inicio) begin
                a_d       = bus.operando1;
                b_d       = bus.operando2;
                cnt_d     = '0;
                data_uc_d = 1'b0;
                erro_d    = 1'b0;
                if (bus.opcode == OP_MUL) begin
                    trab_d   = {{L{1'b0}}, bus.operando2};
                    estado_d = MUL;
                end else if (bus.opcode == OP_DIV) begin
                    trab_d   = {{L{1'b0}}, bus.operando1};
                    erro_d   = (bus.operando2 == '0);
                    estado_d = DIV;
                end else begin
                    resultado_d = imed_res;
                    data_uc_d   = imed_uc;
                    estado_d    = FIM;
                end
            end
            MUL: begin
                trab_d = mul_prox;
                cnt_d  = cnt_q + CW'(1);
                if (ultima) begin
                    resultado_d = mul_prox;
                    cnt_d       = '0;
                    estado_d    = FIM;
                end
            end
            DIV: begin
                trab_d = div_prox;
                cnt_d  = cnt_q + CW'(1);
                if (ultima) begin
                    resultado_d = div_prox;
                    cnt_d       = '0;
                    estado_d    = FIM;
                end
            end
            default: estado_d = OCIOSO;
        endcase
        pronto_d  = (estado_d == FIM);
        ocupado_d = (estado_d != OCIOSO);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            a_q         <= '0;
            b_q         <= '0;
            trab_q      <= '0;
            cnt_q       <= '0;
            resultado_q <= '0;
            data_uc_q   <= 1'b0;
            erro_q      <= 1'b0;
            pronto_q    <= 1'b0;
            ocupado_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            a_q         <= a_d;
            b_q         <= b_d;
            trab_q      <= trab_d;
            cnt_q       <= cnt_d;
            resultado_q <= resultado_d;
            data_uc_q   <= data_uc_d;
            erro_q      <= erro_d;
            pronto_q    <= pronto_d;
            ocupado_q   <= ocupado_d;
        end
    end

    assign bus.ocupado   = ocupado_q;
    assign bus.pronto    = pronto_q;
    assign bus.resultado = resultado_q;
    assign bus.data_uc   = data_uc_q;
    assign bus.erro_div0 = erro_q;
endmodule

// File: tb/tb_ula_sequencial.sv
// Randomized and directed bench for ula_sequencial against a transaction-level reference model.
module tb_ula_sequencial;
    localparam int L = 16;

    localparam logic [4:0] OP_PUSH = 5'b00010, OP_ADD = 5'b00100, OP_SUB = 5'b00101,
                           OP_MUL = 5'b00110, OP_DIV = 5'b00111, OP_AND = 5'b01000,
                           OP_NAND = 5'b01001, OP_OR = 5'b01010, OP_XOR = 5'b01011,
                           OP_CMP = 5'b01100, OP_NOT = 5'b01101, OP_IFEQ = 5'b01111,
                           OP_IFGT = 5'b10000, OP_IFLT = 5'b10001, OP_IFGE = 5'b10010,
                           OP_IFLE = 5'b10011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ula_sequencial_if #(.LARGURA(L)) bus();
    ula_sequencial #(.LARGURA(L)) dut (.clock(clk), .reset(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;
    int pronto_cnt = 0;

    logic [4:0] ops_tab [0:15] = '{OP_PUSH, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_NAND,
                                   OP_OR, OP_XOR, OP_CMP, OP_NOT, OP_IFEQ, OP_IFGT, OP_IFLT,
                                   OP_IFGE, OP_IFLE};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Reference semantics straight from the opcode table, using plain integer arithmetic.
    function automatic void ula_ref(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [31:0] r, output logic uc, output logic e);
        int sa;
        logic [15:0] t;
        r = 32'h0; uc = 1'b0; e = 1'b0; t = 16'h0;
        sa = $signed(a);
        case (op)
            OP_PUSH: r = {16'h0, a};
            OP_ADD:  r = 32'(a) + 32'(b);
            OP_SUB:  r = 32'(a) - 32'(b);
            OP_MUL:  r = 32'(a) * 32'(b);
            OP_DIV: begin
                if (b == 16'h0) begin r = {a, 16'hFFFF}; e = 1'b1; end
                else r = {a % b, a / b};
            end
            OP_AND:  begin t = a & b;    r = {16'h0, t}; end
            OP_NAND: begin t = ~(a & b); r = {16'h0, t}; end
            OP_OR:   begin t = a | b;    r = {16'h0, t}; end
            OP_XOR:  begin t = a ^ b;    r = {16'h0, t}; end
            OP_NOT:  begin t = ~a;       r = {16'h0, t}; end
            OP_CMP:  r = (a == b) ? 32'h0 : (a > b) ? 32'h1 : 32'hFFFF_FFFF;
            OP_IFEQ: uc = (sa == 0);
            OP_IFGT: uc = (sa > 0);
            OP_IFLT: uc = (sa < 0);
            OP_IFGE: uc = (sa >= 0);
            OP_IFLE: uc = (sa <= 0);
            default: ;
        endcase
    endfunction

    // Transaction-level timing model: accept when idle, pronto after a fixed latency, idle one edge later.
    int cyc = 0;
    int pronto_edge = -10;
    bit m_busy = 0;
    bit exp_pronto = 0;
    bit exp_ocup = 0;
    logic [31:0] m_res = 32'h0, p_res = 32'h0;
    logic m_uc = 1'b0, m_err = 1'b0, p_uc = 1'b0, p_err = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 0; m_res = 32'h0; m_uc = 1'b0; m_err = 1'b0;
        end else if (m_busy) begin
            if (cyc == pronto_edge + 1) m_busy = 0;
        end else if (bus.inicio === 1'b1) begin
            ula_ref(bus.opcode, bus.operando1, bus.operando2, p_res, p_uc, p_err);
            m_busy = 1;
            pronto_edge = cyc + ((bus.opcode == OP_MUL || bus.opcode == OP_DIV) ? L : 0);
        end
        exp_pronto = m_busy && (cyc == pronto_edge);
        if (exp_pronto) begin
            m_res = p_res; m_uc = p_uc; m_err = p_err;
        end
        exp_ocup = m_busy;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.pronto === 1'b1) pronto_cnt++;
            chk("ocupado", 32'(bus.ocupado), 32'(exp_ocup));
            chk("pronto", 32'(bus.pronto), 32'(exp_pronto));
            if (!exp_ocup || exp_pronto) begin
                chk("resultado", bus.resultado, m_res);
                chk("data_uc", 32'(bus.data_uc), 32'(m_uc));
                chk("erro_div0", 32'(bus.erro_div0), 32'(m_err));
            end
        end
    end

    task automatic do_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] r, output logic uc, output logic e, output int lat);
        @(negedge clk);
        bus.inicio = 1'b1; bus.opcode = op; bus.operando1 = a; bus.operando2 = b;
        @(negedge clk);
        bus.inicio = 1'b0;
        bus.opcode = 5'($urandom); bus.operando1 = 16'($urandom); bus.operando2 = 16'($urandom);
        lat = 1;
        while (bus.pronto !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (bus.pronto !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL timeout op=%b: no pronto within %0d cycles, required one", op, lat);
        end
        r = bus.resultado; uc = bus.data_uc; e = bus.erro_div0;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'hFFFF;
            3: return 16'h8000;
            4: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    logic [31:0] r;
    logic uc, e;
    int lat, p0, k;

    initial begin
        rst = 1'b1;
        bus.inicio = 1'b0; bus.opcode = 5'h0; bus.operando1 = 16'h0; bus.operando2 = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst_pronto", 32'(bus.pronto), 32'd0);
        chk("rst_resultado", bus.resultado, 32'd0);
        chk("rst_data_uc", 32'(bus.data_uc), 32'd0);
        chk("rst_erro", 32'(bus.erro_div0), 32'd0);
        chk_en = 1;
        rst = 1'b0;

        // Pin the reference model on a few hand-computed points.
        ula_ref(OP_DIV, 16'd1000, 16'd7, r, uc, e);
        chk("model_div", r, 32'h0006_008E);
        ula_ref(OP_SUB, 16'd3, 16'd5, r, uc, e);
        chk("model_sub", r, 32'hFFFF_FFFE);
        ula_ref(OP_IFLE, 16'hFFFF, 16'd0, r, uc, e);
        chk("model_ifle", 32'(uc), 32'd1);

        do_op(OP_MUL, 16'd300, 16'd200, r, uc, e, lat);
        chk("mul_300x200", r, 32'd60000);
        chk("mul_latency", 32'(lat), 32'd17);
        do_op(OP_MUL, 16'hFFFF, 16'hFFFF, r, uc, e, lat);
        chk("mul_ffff", r, 32'hFFFE_0001);
        do_op(OP_DIV, 16'd1000, 16'd7, r, uc, e, lat);
        chk("div_1000_7", r, 32'h0006_008E);
        chk("div_err0", 32'(e), 32'd0);
        chk("div_latency", 32'(lat), 32'd17);
        do_op(OP_DIV, 16'd5, 16'd0, r, uc, e, lat);
        chk("div_5_0", r, 32'h0005_FFFF);
        chk("div0_err", 32'(e), 32'd1);
        chk("div0_latency", 32'(lat), 32'd17);
        do_op(OP_ADD, 16'hFFFF, 16'd1, r, uc, e, lat);
        chk("add_carry", r, 32'h0001_0000);
        chk("add_latency", 32'(lat), 32'd1);
        chk("add_clears_err", 32'(e), 32'd0);
        do_op(OP_SUB, 16'd3, 16'd5, r, uc, e, lat);
        chk("sub_borrow", r, 32'hFFFF_FFFE);
        do_op(OP_CMP, 16'd2, 16'd9, r, uc, e, lat);
        chk("cmp_less", r, 32'hFFFF_FFFF);
        do_op(OP_NOT, 16'h00FF, 16'h1234, r, uc, e, lat);
        chk("not_00ff", r, 32'h0000_FF00);
        do_op(OP_IFLT, 16'h8000, 16'h0, r, uc, e, lat);
        chk("iflt_uc", 32'(uc), 32'd1);
        chk("iflt_res", r, 32'd0);
        do_op(OP_IFGT, 16'h8000, 16'h0, r, uc, e, lat);
        chk("ifgt_uc", 32'(uc), 32'd0);
        chk("ifgt_res", r, 32'd0);
        do_op(OP_IFGE, 16'h0000, 16'h0, r, uc, e, lat);
        chk("ifge_uc", 32'(uc), 32'd1);
        chk("ifge_res", r, 32'd0);
        do_op(OP_IFEQ, 16'h0001, 16'h0, r, uc, e, lat);
        chk("ifeq_uc", 32'(uc), 32'd0);
        chk("ifeq_res", r, 32'd0);

        // Add requested while a Mul is running must be dropped.
        #1 p0 = pronto_cnt;
        @(negedge clk);
        bus.inicio = 1'b1; bus.opcode = OP_MUL; bus.operando1 = 16'd123; bus.operando2 = 16'd45;
        @(negedge clk);
        bus.inicio = 1'b0;
        repeat (3) @(negedge clk);
        bus.inicio = 1'b1; bus.opcode = OP_ADD; bus.operando1 = 16'd7; bus.operando2 = 16'd8;
        repeat (4) @(negedge clk);
        bus.inicio = 1'b0;
        k = 0;
        while (bus.pronto !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("busy_mul_res", bus.resultado, 32'd5535);
        repeat (3) @(negedge clk);
        #1 chk("busy_pronto_pulses", 32'(pronto_cnt - p0), 32'd1);

        // Reset in cycle 8 of a Mul.
        @(negedge clk);
        bus.inicio = 1'b1; bus.opcode = OP_MUL; bus.operando1 = 16'd1000; bus.operando2 = 16'd1000;
        @(negedge clk);
        bus.inicio = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmul_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rstmul_pronto", 32'(bus.pronto), 32'd0);
        chk("rstmul_resultado", bus.resultado, 32'd0);
        rst = 1'b0;
        do_op(OP_ADD, 16'h1234, 16'h0FFF, r, uc, e, lat);
        chk("post_rst_add", r, 32'h0000_2233);
        chk("post_rst_latency", 32'(lat), 32'd1);

        // Free-running random traffic, including held inicio, illegal opcodes and stray resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 249) == 0);
            bus.inicio = ($urandom_range(0, 3) != 0);
            bus.opcode = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops_tab[$urandom_range(0, 15)];
            bus.operando1 = pick_operand();
            bus.operando2 = pick_operand();
        end
        @(negedge clk);
        rst = 1'b0;
        bus.inicio = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
